vga_sync_decoder: RTL

- Recovers pixel position from a 640x480@60 VGA sync pair (VGA_HS_O / VGA_VS_O style, active-low syncs). It is the decoding counterpart to the timing generator.
- Used as a frame-locked position source for logic that sees only the syncs: overlay and capture logic, and bench-side checking of the display path.
- Reports lock status, per-pixel position, active-region flag, a frame-start pulse and timing errors.

---
 rtl/vga_sync_decoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position, lock state and timing errors from an active-low VGA HS/VS pair.
// Latency: outputs register on the same CLK edge as the sampling pixel strobe (1 CLK).
// Backpressure: none; free-running observer, all state advances only on i_pix_stb.
module vga_sync_decoder #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_TOTAL    = 800,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_TOTAL    = 525,
   parameter int LOCK_LINES = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic       CLK,
   input  logic       RST_BTN,
   input  logic       i_pix_stb,
   input  logic       i_hs,
   input  logic       i_vs,
   output logic [9:0] o_x,
   output logic [8:0] o_y,
   output logic       o_active,
   output logic       o_locked,
   output logic       o_frame_start,
   output logic       o_err
);

   typedef enum logic [1:0] {UNLOCKED, H_LOCK, LOCKED} state_t;

   state_t      state_q;
   logic [9:0]  hcnt_q, hcnt_d;
   logic [9:0]  vcnt_q, vcnt_d;
   logic        hs_q, vs_q;
   logic [10:0] line_q, line_d;     // strobes since the last HS fall
   logic [9:0]  width_q, width_d;   // strobes with HS low in the current pulse
   logic [10:0] tmo_q, tmo_d;       // strobes since the last HS fall or timeout
   logic [9:0]  frame_q, frame_d;   // HS falls since the last VS fall
   logic [3:0]  good_q;
   logic        first_edge_q;

   logic hs_fall, hs_rise, vs_fall, h_wrap;
   logic good_line, line_err, width_err, tmo_err, frame_err, any_err;
   logic lock_nxt;

   // Edge detection, counter next-states and error classification for the current strobe
   always_comb begin
      hs_fall   = hs_q & ~i_hs;
      hs_rise   = ~hs_q & i_hs;
      vs_fall   = vs_q & ~i_vs;
      // A forced HS resync takes priority over the natural end-of-line wrap
      h_wrap    = ~hs_fall && (hcnt_q == 10'(H_TOTAL - 1));

      hcnt_d    = hs_fall ? 10'(H_ACTIVE + H_FP) : (h_wrap ? 10'd0 : hcnt_q + 10'd1);
      vcnt_d    = vs_fall ? 10'(V_ACTIVE + V_FP) :
                  (h_wrap ? ((vcnt_q == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt_q + 10'd1) : vcnt_q);

      // Line length is only judged once a previous HS fall has armed the counter
      good_line = hs_fall && first_edge_q && (line_q == 11'(H_TOTAL));
      line_err  = hs_fall && first_edge_q && (line_q != 11'(H_TOTAL));
      width_err = hs_rise && (width_q != 10'(H_SYNC));
      tmo_err   = ~hs_fall && (tmo_q == 11'(TIMEOUT - 1));
      frame_err = vs_fall && (state_q == LOCKED) && (frame_q != 10'(V_TOTAL));
      any_err   = line_err | width_err | tmo_err | frame_err;

      line_d    = hs_fall ? 11'd1 : ((line_q == '1) ? line_q : line_q + 11'd1);
      width_d   = hs_fall ? 10'd1 : ((~i_hs && (width_q != '1)) ? width_q + 10'd1 : width_q);
      tmo_d     = (hs_fall || tmo_err) ? 11'd0 : tmo_q + 11'd1;
      frame_d   = vs_fall ? {9'd0, hs_fall} :
                  ((hs_fall && (frame_q != '1)) ? frame_q + 10'd1 : frame_q);

      // Lock status after this strobe; an error drops lock on the same edge
      lock_nxt  = ~any_err && ((state_q == LOCKED) || ((state_q == H_LOCK) && vs_fall));
   end

   // Strobe-qualified state, lock FSM and registered outputs; pulses clear between strobes
   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         state_q       <= UNLOCKED;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         line_q        <= '0;
         width_q       <= '0;
         tmo_q         <= '0;
         frame_q       <= '0;
         good_q        <= '0;
         first_edge_q  <= 1'b0;
         o_x           <= '0;
         o_y           <= '0;
         o_active      <= 1'b0;
         o_locked      <= 1'b0;
         o_frame_start <= 1'b0;
         o_err         <= 1'b0;
      end else if (i_pix_stb) begin
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         hs_q    <= i_hs;
         vs_q    <= i_vs;
         line_q  <= line_d;
         width_q <= width_d;
         tmo_q   <= tmo_d;
         frame_q <= frame_d;
         if (hs_fall) first_edge_q <= 1'b1;

         case (state_q)
            UNLOCKED: begin
               if (any_err) begin
                  good_q <= '0;
               end else if (good_line) begin
                  good_q <= good_q + 4'd1;
                  if (good_q == 4'(LOCK_LINES - 1)) state_q <= H_LOCK;
               end
            end
            H_LOCK, LOCKED: begin
               // Losing lock re-arms line measurement from scratch
               if (any_err) begin
                  state_q      <= UNLOCKED;
                  good_q       <= '0;
                  first_edge_q <= 1'b0;
               end else if ((state_q == H_LOCK) && vs_fall) begin
                  state_q <= LOCKED;
               end
            end
            default: state_q <= UNLOCKED;
         endcase

         o_x           <= (hcnt_d > 10'(H_ACTIVE - 1)) ? 10'(H_ACTIVE - 1) : hcnt_d;
         o_y           <= (vcnt_d > 10'(V_ACTIVE - 1)) ? 9'(V_ACTIVE - 1) : vcnt_d[8:0];
         o_locked      <= lock_nxt;
         o_active      <= lock_nxt && (hcnt_d < 10'(H_ACTIVE)) && (vcnt_d < 10'(V_ACTIVE));
         o_frame_start <= lock_nxt && (hcnt_d == 10'd0) && (vcnt_d == 10'd0);
         o_err         <= any_err;
      end else begin
         o_frame_start <= 1'b0;
         o_err         <= 1'b0;
      end
   end

endmodule
